uart_xmit: RTL and testbench
============================

Name: uart_xmit

Overview:
UART transmitter, companion to the line-follower's UART receiver. Serialises one byte per frame onto TX: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit BAUD_DIV clocks long. A one-entry holding register lets the controller queue the next byte while a frame is in flight, so back-to-back frames go out with no idle gap. Sits between the command/telemetry logic and the TX pad.

Parameters:
BAUD_DIV, 2604, clocks per bit period (same bit timing as the receiver); legal range 2..4095.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
tx_data  input  8  byte to send; sampled only in the cycle trmt=1.
trmt  input  1  single-cycle request to send tx_data.
clr_tx_done  input  1  clears tx_done.
TX  output  1  serial line; idles high.
tx_busy  output  1  high while a frame is on the line.
tx_full  output  1  high while the holding register holds a queued byte.
tx_done  output  1  sticky frame-complete flag.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (rst). All state updates on posedge clk only.
- Reset values: TX=1, tx_busy=0, tx_full=0, tx_done=0, state=IDLE, counters=0. A reset mid-frame aborts the frame, drops any queued byte, and drives TX=1 on the next cycle.
- State machine: IDLE and XMIT.
  - IDLE: TX=1.
  - IDLE with trmt=1 at edge 0: the frame loads directly. The holding register is not used. State goes to XMIT, and tx_busy=1 from cycle 1.
  - XMIT: 10-bit shift register {1, data[7:0], 0}; TX = its LSB.
  - XMIT: baud counter counts 0..BAUD_DIV-1. At BAUD_DIV-1 the counter wraps to 0, the shift register shifts right (filling with 1), and the bit counter increments.
  - XMIT: when the bit counter reaches 10 at a wrap, the frame ends.
- Frame timing, trmt at edge 0:
  - Start bit on cycles 1..B.
  - Data bit i on cycles 1+(i+1)B .. (i+2)B.
  - Stop bit on cycles 1+9B .. 10B.
  - tx_busy=1 on cycles 1..10B.
  - tx_done=1 from cycle 10B+1.
  - Total latency from trmt to the start-bit edge: 1 cycle.
- Holding register:
  - trmt=1 while XMIT and tx_full=0: tx_data is captured; tx_full=1 from the next cycle.
  - trmt=1 while tx_full=1: request ignored; held byte unchanged.
  - At frame end with tx_full=1: the held byte loads immediately. TX drops to 0 on cycle 10B+1 (no idle gap), tx_busy stays 1, and tx_full=0 from cycle 10B+1.
  - trmt on the exact frame-end cycle with tx_full=0: treated as an IDLE start. The new frame starts on cycle 10B+1, same as the queued case.
- tx_done:
  - Set on every frame completion.
  - Cleared by clr_tx_done.
  - Set wins over a simultaneous clr_tx_done.
  - Not cleared by trmt.
- Widths: baud counter 12 bits; bit counter 4 bits. No other arithmetic.

Test Plan:
1. Reset, then trmt with tx_data=8'hA5, BAUD_DIV=16 → TX bit sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles starting cycle 1; tx_busy high cycles 1..160; tx_done rises at cycle 161 and holds until clr_tx_done.
2. Back-to-back: trmt 8'h3C at cycle 0, trmt 8'hC3 at cycle 5 → tx_full=1 from cycle 6 to 160; second start bit begins at cycle 161 with no high gap; tx_busy continuous through cycle 320; receiver loopback decodes 3C then C3.
3. Overflow: trmt at cycles 0, 5, 9 with data 11, 22, 33 → only 11 and 22 transmitted; 33 dropped; tx_full never deasserts between cycles 6 and 160.
4. Simultaneous clr_tx_done and frame completion at cycle 161 → tx_done=1 at cycle 161; one cycle of clr_tx_done afterwards clears it.
5. rst asserted at cycle 50 mid-frame with a byte queued → TX=1, tx_busy=0, tx_full=0, tx_done=0 next cycle; later trmt 8'h00 sends a clean frame from cycle 1 after request.
6. Default BAUD_DIV=2604, loopback into the receiver with bytes 8'h00, 8'hFF, 8'h55 → rx_data matches each byte, rx_rdy set per frame; frame length 26040 cycles.

Source files
------------

// File: rtl/uart_xmit.sv
// UART transmitter: 8N1 frames, BAUD_DIV clocks per bit, with a one-entry
// holding register so a queued byte follows the current frame with no idle gap.
module uart_xmit #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    input  logic       clr_tx_done,
    output logic       TX,
    output logic       tx_busy,
    output logic       tx_full,
    output logic       tx_done
);

    localparam logic [11:0] BAUD_MAX = 12'(BAUD_DIV - 1);

    typedef enum logic {IDLE, XMIT} state_t;

    state_t      state, next_state;
    logic [9:0]  shift;
    logic [11:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  hold;
    logic        full;
    logic        done;

    logic        bit_wrap;
    logic        frame_end;
    logic        load;
    logic [7:0]  load_data;
    logic        capture;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // A frame end either chains straight into the queued byte, accepts a
    // same-cycle request as a fresh start, or drops back to IDLE.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_data  = tx_data;
        bit_wrap   = (state == XMIT) && (baud_cnt == BAUD_MAX);
        frame_end  = bit_wrap && (bit_cnt == 4'd9);
        case (state)
            IDLE: begin
                if (trmt) begin
                    load       = 1'b1;
                    next_state = XMIT;
                end
            end
            XMIT: begin
                if (frame_end) begin
                    if (full) begin
                        load      = 1'b1;
                        load_data = hold;
                    end else if (trmt) begin
                        load = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        capture = (state == XMIT) && trmt && !full && !frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift    <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            hold     <= '0;
            full     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (load) begin
                shift    <= {1'b1, load_data, 1'b0};
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (bit_wrap) begin
                shift    <= {1'b1, shift[9:1]};
                baud_cnt <= '0;
                bit_cnt  <= frame_end ? 4'd0 : bit_cnt + 4'd1;
            end else if (state == XMIT) begin
                baud_cnt <= baud_cnt + 12'd1;
            end

            if (load && full) begin
                full <= 1'b0;
            end else if (capture) begin
                hold <= tx_data;
                full <= 1'b1;
            end

            if (frame_end)        done <= 1'b1;
            else if (clr_tx_done) done <= 1'b0;
        end
    end

    assign TX      = shift[0];
    assign tx_busy = (state == XMIT);
    assign tx_full = full;
    assign tx_done = done;

endmodule

// File: tb/tb_uart_xmit.sv
// Directed bench for uart_xmit: a BAUD_DIV=16 instance for timing/queue cases
// and a default-rate instance decoded by a mid-bit sampling receiver.
module tb_uart_xmit;

    localparam int B = 16;
    localparam int BD = 2604;

    logic clk = 1'b0;
    logic rst;

    logic [7:0] a_data, b_data;
    logic a_trmt, a_clr, b_trmt, b_clr;
    logic a_tx, a_busy, a_full, a_done;
    logic b_tx, b_busy, b_full, b_done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    uart_xmit #(.BAUD_DIV(B)) dut_a (
        .clk(clk), .rst(rst), .tx_data(a_data), .trmt(a_trmt),
        .clr_tx_done(a_clr), .TX(a_tx), .tx_busy(a_busy),
        .tx_full(a_full), .tx_done(a_done)
    );

    uart_xmit dut_b (
        .clk(clk), .rst(rst), .tx_data(b_data), .trmt(b_trmt),
        .clr_tx_done(b_clr), .TX(b_tx), .tx_busy(b_busy),
        .tx_full(b_full), .tx_done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] frame(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    // Request d0 at cycle 0, optional extra requests at c1/c2, clr_tx_done at clr_c.
    // Checks TX/tx_busy/tx_full every cycle of nfr frames, then the idle state.
    task automatic run_a(input logic [7:0] d0, input int c1, input logic [7:0] d1,
                         input int c2, input logic [7:0] d2, input int nfr,
                         input logic [7:0] f1, input int clr_c);
        logic [9:0] f;
        logic fe;
        a_data = d0;
        a_trmt = 1'b1;
        step();
        a_trmt = 1'b0;
        for (int c = 1; c <= nfr * 10 * B; c++) begin
            f = frame(((c - 1) / (10 * B) == 0) ? d0 : f1);
            chk("a_tx_bit", {31'd0, a_tx}, {31'd0, f[((c - 1) % (10 * B)) / B]});
            chk("a_busy", {31'd0, a_busy}, 32'd1);
            fe = (c1 > 0) && (c >= c1 + 1) && (c <= 10 * B);
            chk("a_full", {31'd0, a_full}, {31'd0, fe});
            a_trmt = 1'b0;
            a_clr  = 1'b0;
            if (c == c1) begin a_trmt = 1'b1; a_data = d1; end
            if (c == c2) begin a_trmt = 1'b1; a_data = d2; end
            if (c == clr_c) a_clr = 1'b1;
            step();
        end
        a_trmt = 1'b0;
        a_clr  = 1'b0;
        chk("a_end_tx", {31'd0, a_tx}, 32'd1);
        chk("a_end_busy", {31'd0, a_busy}, 32'd0);
        chk("a_end_full", {31'd0, a_full}, 32'd0);
        chk("a_end_done", {31'd0, a_done}, 32'd1);
        step();
        chk("a_idle_tx", {31'd0, a_tx}, 32'd1);
        chk("a_idle_busy", {31'd0, a_busy}, 32'd0);
    endtask

    task automatic run_b(input logic [7:0] d);
        logic [9:0] rx;
        int busy_cnt;
        rx = '0;
        busy_cnt = 0;
        b_data = d;
        b_trmt = 1'b1;
        step();
        b_trmt = 1'b0;
        for (int c = 1; c <= 10 * BD; c++) begin
            if (b_busy) busy_cnt++;
            if ((c - 1) % BD == BD / 2) rx = {b_tx, rx[9:1]};
            step();
        end
        chk("b_start", {31'd0, rx[0]}, 32'd0);
        chk("b_stop", {31'd0, rx[9]}, 32'd1);
        chk("b_rx_data", {24'd0, rx[8:1]}, {24'd0, d});
        chk("b_frame_len", busy_cnt, 10 * BD);
        chk("b_busy_end", {31'd0, b_busy}, 32'd0);
        chk("b_done", {31'd0, b_done}, 32'd1);
        b_clr = 1'b1;
        step();
        b_clr = 1'b0;
        chk("b_done_clr", {31'd0, b_done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        a_data = '0; a_trmt = 1'b0; a_clr = 1'b0;
        b_data = '0; b_trmt = 1'b0; b_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_tx", {31'd0, a_tx}, 32'd1);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_full", {31'd0, a_full}, 32'd0);
        chk("rst_done", {31'd0, a_done}, 32'd0);
        chk("rst_b_tx", {31'd0, b_tx}, 32'd1);

        // Test 1: single A5 frame, sticky done until cleared
        run_a(8'hA5, -1, 8'h00, -1, 8'h00, 1, 8'h00, -1);
        chk("t1_a5_bits", {22'd0, frame(8'hA5)}, {22'd0, 10'b1101001010});
        for (int i = 0; i < 4; i++) step();
        chk("t1_done_hold", {31'd0, a_done}, 32'd1);
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        chk("t1_done_clr", {31'd0, a_done}, 32'd0);
        step();

        // Test 2: back-to-back 3C then C3
        run_a(8'h3C, 5, 8'hC3, -1, 8'h00, 2, 8'hC3, -1);
        step();

        // Test 3: overflow, third request dropped
        run_a(8'h11, 5, 8'h22, 9, 8'h33, 2, 8'h22, -1);
        for (int i = 0; i < 3; i++) begin
            chk("t3_no_third", {31'd0, a_busy}, 32'd0);
            step();
        end

        // Test 5: reset mid-frame with a byte queued (done still set from test 3)
        a_data = 8'h5A;
        a_trmt = 1'b1;
        step();
        a_trmt = 1'b0;
        for (int c = 1; c < 50; c++) begin
            a_trmt = (c == 5);
            a_data = 8'h77;
            step();
        end
        a_trmt = 1'b0;
        chk("t5_pre_full", {31'd0, a_full}, 32'd1);
        chk("t5_pre_done", {31'd0, a_done}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_tx", {31'd0, a_tx}, 32'd1);
        chk("t5_rst_busy", {31'd0, a_busy}, 32'd0);
        chk("t5_rst_full", {31'd0, a_full}, 32'd0);
        chk("t5_rst_done", {31'd0, a_done}, 32'd0);
        step();
        step();
        run_a(8'h00, -1, 8'h00, -1, 8'h00, 1, 8'h00, -1);

        // Test 4: clr_tx_done coincident with frame completion
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        chk("t4_pre_clr", {31'd0, a_done}, 32'd0);
        run_a(8'h96, -1, 8'h00, -1, 8'h00, 1, 8'h00, 10 * B);
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        chk("t4_done_clr", {31'd0, a_done}, 32'd0);

        // Test 6: default baud rate loopback
        run_b(8'h00);
        run_b(8'hFF);
        run_b(8'h55);
        chk("b_full_idle", {31'd0, b_full}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
